// File: rtl/ysyx_22050550_scoreboard_if.sv
// IDU/WBU handshake bundle between the scoreboard and its issue/writeback clients.
// Latency: none, wires only.
// Backpressure: io_IDU_ready is driven by the scoreboard back to IDU.
interface ysyx_22050550_scoreboard_if #(
    parameter int OUT_W = 3
);
    logic             io_IDU_valid;
    logic             io_IDU_ren1;
    logic             io_IDU_ren2;
    logic [4:0]       io_IDU_raddr1;
    logic [4:0]       io_IDU_raddr2;
    logic             io_IDU_wen;
    logic [4:0]       io_IDU_waddr;
    logic             io_IDU_ready;
    logic             io_IDU_pass1;
    logic             io_IDU_pass2;
    logic             io_WBU_valid;
    logic [4:0]       io_WBU_waddr;
    logic             io_busy;
    logic [OUT_W-1:0] io_outstanding;

    // Client side: IDU/WBU drive requests and see the scoreboard verdict.
    modport master (
        output io_IDU_valid, io_IDU_ren1, io_IDU_ren2, io_IDU_raddr1, io_IDU_raddr2,
        output io_IDU_wen, io_IDU_waddr, io_WBU_valid, io_WBU_waddr,
        input  io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_outstanding
    );

    // Scoreboard side.
    modport slave (
        input  io_IDU_valid, io_IDU_ren1, io_IDU_ren2, io_IDU_raddr1, io_IDU_raddr2,
        input  io_IDU_wen, io_IDU_waddr, io_WBU_valid, io_WBU_waddr,
        output io_IDU_ready, io_IDU_pass1, io_IDU_pass2, io_busy, io_outstanding
    );
endinterface

// File: rtl/ysyx_22050550_scoreboard.sv
// Register-hazard scoreboard: counts pending writes per rd, gates IDU issue, flags WBU forwarding.
// Latency: issue visible to hazard checks next cycle; same-cycle writeback resolves via pass.
// Backpressure: io_IDU_ready drops on unresolved RAW or per-register counter saturation.
module ysyx_22050550_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int OUT_W = 3
) (
    input logic clock,
    input logic reset,
    ysyx_22050550_scoreboard_if.slave sb_if
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [OUT_W-1:0] TOT_MAX = {OUT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [OUT_W-1:0] tot_q;
    logic [OUT_W-1:0] tot_d;

    logic wb;
    logic wb_eff;
    logic rs1_haz;
    logic rs2_haz;
    logic rs1_res;
    logic rs2_res;
    logic blocking;
    logic saturation;
    logic ready;
    logic fire;

    // Hazard detection, issue gating and the total-count update.
    always_comb begin
        wb      = sb_if.io_WBU_valid && (sb_if.io_WBU_waddr != 5'd0);
        wb_eff  = wb && (cnt_q[sb_if.io_WBU_waddr] != '0);
        rs1_haz = sb_if.io_IDU_ren1 && (sb_if.io_IDU_raddr1 != 5'd0)
                  && (cnt_q[sb_if.io_IDU_raddr1] != '0);
        rs2_haz = sb_if.io_IDU_ren2 && (sb_if.io_IDU_raddr2 != 5'd0)
                  && (cnt_q[sb_if.io_IDU_raddr2] != '0);
        // Forwarding is only safe when the retiring write is the last one pending.
        rs1_res = (cnt_q[sb_if.io_IDU_raddr1] == CNT_W'(1)) && wb
                  && (sb_if.io_WBU_waddr == sb_if.io_IDU_raddr1);
        rs2_res = (cnt_q[sb_if.io_IDU_raddr2] == CNT_W'(1)) && wb
                  && (sb_if.io_WBU_waddr == sb_if.io_IDU_raddr2);
        blocking   = (rs1_haz && !rs1_res) || (rs2_haz && !rs2_res);
        // A full counter can still accept an issue if a write to it retires now.
        saturation = sb_if.io_IDU_wen && (sb_if.io_IDU_waddr != 5'd0)
                     && (cnt_q[sb_if.io_IDU_waddr] == CNT_MAX)
                     && !(wb && (sb_if.io_WBU_waddr == sb_if.io_IDU_waddr));
        ready = !blocking && !saturation;
        fire  = sb_if.io_IDU_valid && ready && sb_if.io_IDU_wen && (sb_if.io_IDU_waddr != 5'd0);

        tot_d = tot_q;
        if (fire && !wb_eff) begin
            tot_d = (tot_q == TOT_MAX) ? tot_q : tot_q + OUT_W'(1);
        end else if (!fire && wb_eff) begin
            tot_d = (tot_q == '0) ? tot_q : tot_q - OUT_W'(1);
        end
    end

    // Per-register counter update; x0 never holds a pending write.
    always_comb begin
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (fire && (sb_if.io_IDU_waddr == 5'(r))
                && !(wb && (sb_if.io_WBU_waddr == 5'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (wb && (sb_if.io_WBU_waddr == 5'(r))
                         && !(fire && (sb_if.io_IDU_waddr == 5'(r)))
                         && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset overriding issue and writeback.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            tot_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tot_q <= tot_d;
        end
    end

    assign sb_if.io_IDU_ready   = ready;
    assign sb_if.io_IDU_pass1   = sb_if.io_IDU_valid && rs1_haz && rs1_res;
    assign sb_if.io_IDU_pass2   = sb_if.io_IDU_valid && rs2_haz && rs2_res;
    assign sb_if.io_outstanding = tot_q;
    assign sb_if.io_busy        = (tot_q != '0);

`ifndef SYNTHESIS
    // A writeback with nothing pending means a producer lost track of its rd.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(wb && (cnt_q[sb_if.io_WBU_waddr] == '0)))
                else $error("scoreboard underflow on x%0d", sb_if.io_WBU_waddr);
        end
    end
`endif
endmodule
